// File: rtl/vpu_rd_unit.sv
// vpu_rd_unit: VPU operand read unit.
// Fetches one SRAM word and scatters it into EXEC_CNT lane slices.
module vpu_rd_unit #(
  parameter  int SRAM_BANK_CNT_LG2   = 2,
  parameter  int SRAM_BANK_DEPTH_LG2 = 10,
  parameter  int EXEC_CNT            = 4,
  parameter  int DWIDTH_PER_EXEC     = 128,
  localparam int SRAM_DATA_WIDTH     = EXEC_CNT * DWIDTH_PER_EXEC,
  localparam int EXEC_CNT_LG2        = $clog2(EXEC_CNT),
  localparam int RADDR_W             = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           bcast_i,
  input  logic [RADDR_W-1:0]             raddr_i,
  output logic                           done_o,
  output logic                           req_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]   rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] addr_o,
  output logic                           rlast_o,
  input  logic                           ack_i,
  input  logic                           rvalid_i,
  input  logic [SRAM_DATA_WIDTH-1:0]     rdata_i,
  output logic                           lane_valid_o,
  output logic [DWIDTH_PER_EXEC-1:0]     lane_data_o,
  output logic                           lane_last_o,
  input  logic                           lane_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_STREAM
  } state_t;

  localparam logic [EXEC_CNT_LG2-1:0] LAST_CNT =
    EXEC_CNT_LG2'(EXEC_CNT - 1);

  state_t                           r_state;
  logic [EXEC_CNT_LG2-1:0]          r_cnt;
  logic [SRAM_DATA_WIDTH-1:0]       r_buf;
  logic                             r_bcast;
  logic                             r_done;
  logic                             r_req;
  logic                             r_rlast;
  logic [SRAM_BANK_CNT_LG2-1:0]     r_rid;
  logic [SRAM_BANK_DEPTH_LG2-1:0]   r_addr;
  logic                             r_lvalid;

  logic                             w_last;
  logic                             w_hs;
  logic [DWIDTH_PER_EXEC-1:0]       w_slice;

  assign w_last  = r_bcast | (r_cnt == LAST_CNT);
  assign w_hs    = r_lvalid & lane_ready_i;
  assign w_slice = r_buf[DWIDTH_PER_EXEC*int'(r_cnt) +: DWIDTH_PER_EXEC];

  assign done_o       = r_done;
  assign req_o        = r_req;
  assign rlast_o      = r_rlast;
  assign rid_o        = r_rid;
  assign addr_o       = r_addr;
  assign lane_valid_o = r_lvalid;
  assign lane_data_o  = r_lvalid ? w_slice : '0;
  assign lane_last_o  = r_lvalid & w_last;

  // Request / wait / stream sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_bcast  <= 1'b0;
      r_done   <= 1'b1;
      r_req    <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_addr   <= '0;
      r_lvalid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rid   <= raddr_i[RADDR_W-1 -: SRAM_BANK_CNT_LG2];
            r_addr  <= raddr_i[SRAM_BANK_DEPTH_LG2-1:0];
            r_bcast <= bcast_i;
            r_req   <= 1'b1;
            r_rlast <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_i) begin
            r_req   <= 1'b0;
            r_rlast <= 1'b0;
            r_rid   <= '0;
            r_addr  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rvalid_i) begin
            r_buf    <= rdata_i;
            r_cnt    <= '0;
            r_lvalid <= 1'b1;
            r_state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_lvalid <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_rd_unit.sv
// tb_vpu_rd_unit: scoreboard bench for vpu_rd_unit.
// Expected slices are queued at stimulus time and popped on lane handshakes.
module tb_vpu_rd_unit;

  localparam int BK  = 2;
  localparam int DP  = 10;
  localparam int EC  = 4;
  localparam int DW  = 128;
  localparam int SW  = EC * DW;
  localparam int AW  = BK + DP;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic          bcast_i;
  logic [AW-1:0] raddr_i;
  logic          done_o;
  logic          req_o;
  logic [BK-1:0] rid_o;
  logic [DP-1:0] addr_o;
  logic          rlast_o;
  logic          ack_i;
  logic          rvalid_i;
  logic [SW-1:0] rdata_i;
  logic          lane_valid_o;
  logic [DW-1:0] lane_data_o;
  logic          lane_last_o;
  logic          lane_ready_i;

  vpu_rd_unit #(
    .SRAM_BANK_CNT_LG2  (BK),
    .SRAM_BANK_DEPTH_LG2(DP),
    .EXEC_CNT           (EC),
    .DWIDTH_PER_EXEC    (DW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .bcast_i     (bcast_i),
    .raddr_i     (raddr_i),
    .done_o      (done_o),
    .req_o       (req_o),
    .rid_o       (rid_o),
    .addr_o      (addr_o),
    .rlast_o     (rlast_o),
    .ack_i       (ack_i),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i),
    .lane_valid_o(lane_valid_o),
    .lane_data_o (lane_data_o),
    .lane_last_o (lane_last_o),
    .lane_ready_i(lane_ready_i)
  );

  int            n_chk;
  int            n_err;
  int            cyc;
  int            n_req;
  int            n_pop;
  int            exp_req;
  logic [DW-1:0] sb_q[$];
  logic          bp_en;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [6:0]    bp_pat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Lane ready driver: constant 1 or the 1,0,0,1,0,1,1 pattern
  initial begin
    int idx;
    idx = 0;
    bp_pat = 7'b1101001;
    lane_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lane_ready_i = bp_en ? bp_pat[idx] : 1'b1;
      idx = (idx + 1) % 7;
    end
  end

  // Monitor: scoreboard pops, hold-under-stall, request counting
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", lane_data_o, prev_data);
      if (req_o && ack_i)
        n_req++;
      if (lane_valid_o && lane_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("extra_beat", 128'(lane_valid_o), 128'(0));
        end else begin
          logic [DW-1:0] e;
          e = sb_q.pop_front();
          n_pop++;
          chk("slice", lane_data_o, e);
          chk("last", 128'(lane_last_o), 128'(sb_q.size() == 0));
        end
      end
      prev_stall = lane_valid_o && !lane_ready_i;
      prev_data  = lane_data_o;
    end
  end

  function automatic logic [SW-1:0] rnd_word();
    logic [SW-1:0] w;
    for (int i = 0; i < SW / 32; i++)
      w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic run_op(
    input logic [BK-1:0] bank,
    input logic [DP-1:0] addr,
    input logic          bc,
    input logic [SW-1:0] word,
    input int            ack_lat,
    input logic          spur,
    input int            exp_lat,
    input int            rst_at
  );
    int t0;
    bit got;
    n_pop = 0;
    if (bc) begin
      sb_q.push_back(word[DW-1:0]);
    end else begin
      for (int k = 0; k < EC; k++)
        sb_q.push_back(word[k*DW +: DW]);
    end
    if (spur) begin
      @(posedge clk);
      #1;
      rvalid_i = 1'b1;
      rdata_i  = rnd_word();
      @(negedge clk);
      chk("idle_rv_done", 128'(done_o), 128'(1));
      chk("idle_rv_valid", 128'(lane_valid_o), 128'(0));
    end
    @(posedge clk);
    #1;
    rvalid_i = 1'b0;
    start_i  = 1'b1;
    bcast_i  = bc;
    raddr_i  = {bank, addr};
    @(posedge clk);
    #1;
    t0       = cyc;
    start_i  = 1'b0;
    bcast_i  = 1'b0;
    raddr_i  = '0;
    ack_i    = (ack_lat == 0);
    if (spur && ack_lat == 0) begin
      rvalid_i = 1'b1;
      rdata_i  = rnd_word();
    end
    exp_req++;
    for (int i = 0; i <= ack_lat; i++) begin
      @(negedge clk);
      chk("req", 128'(req_o), 128'(1));
      chk("rlast", 128'(rlast_o), 128'(1));
      chk("rid", 128'(rid_o), 128'(bank));
      chk("addr", 128'(addr_o), 128'(addr));
      chk("done_low", 128'(done_o), 128'(0));
      if (i < ack_lat) begin
        @(posedge clk);
        #1;
        ack_i = (i + 1 == ack_lat);
        if (spur && i + 1 == ack_lat) begin
          rvalid_i = 1'b1;
          rdata_i  = rnd_word();
        end
      end
    end
    @(posedge clk);
    #1;
    ack_i    = 1'b0;
    rvalid_i = 1'b1;
    rdata_i  = word;
    @(negedge clk);
    chk("req_drop", 128'(req_o), 128'(0));
    chk("rid_clr", 128'(rid_o), 128'(0));
    chk("addr_clr", 128'(addr_o), 128'(0));
    @(posedge clk);
    #1;
    rvalid_i = 1'b0;
    rdata_i  = rnd_word();
    if (spur) start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      #2;
      if (rst_at != 0 && n_pop == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 128'(lane_valid_o), 128'(0));
        chk("rst_req", 128'(req_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(1));
        chk("rst_data", lane_data_o, 128'(0));
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (done_o) got = 1'b1;
    end
    chk("done_timeout", 128'(got), 128'(1));
    if (exp_lat != 0)
      chk("latency", 128'(cyc - t0 + 1), 128'(exp_lat));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("post_req", 128'(req_o), 128'(0));
      chk("post_done", 128'(done_o), 128'(1));
    end
  endtask

  initial begin
    logic [SW-1:0] w;
    n_chk      = 0;
    n_err      = 0;
    cyc        = 0;
    n_req      = 0;
    n_pop      = 0;
    exp_req    = 0;
    bp_en      = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    bcast_i    = 1'b0;
    raddr_i    = '0;
    ack_i      = 1'b0;
    rvalid_i   = 1'b0;
    rdata_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 128'(done_o), 128'(1));
    chk("rst_req", 128'(req_o), 128'(0));
    chk("rst_rlast", 128'(rlast_o), 128'(0));
    chk("rst_rid", 128'(rid_o), 128'(0));
    chk("rst_addr", 128'(addr_o), 128'(0));
    chk("rst_lvalid", 128'(lane_valid_o), 128'(0));
    chk("rst_ldata", lane_data_o, 128'(0));
    chk("rst_llast", 128'(lane_last_o), 128'(0));
    rst_n = 1'b1;

    for (int k = 0; k < EC; k++)
      w[k*DW +: DW] = {4{32'hA0 + 32'(k)}};
    run_op(2'd2, 10'h155, 1'b0, w, 0, 1'b0, 7, 0);

    run_op(2'd1, 10'h2A3, 1'b0, rnd_word(), 5, 1'b0, 0, 0);

    bp_en = 1'b1;
    run_op(2'd3, 10'h001, 1'b0, rnd_word(), 0, 1'b0, 0, 0);
    bp_en = 1'b0;

    run_op(2'd0, 10'h3FF, 1'b1, rnd_word(), 0, 1'b0, 4, 0);

    run_op(2'd2, 10'h0F0, 1'b0, rnd_word(), 0, 1'b1, 0, 0);
    run_op(2'd1, 10'h111, 1'b0, rnd_word(), 2, 1'b1, 0, 0);

    bp_en = 1'b1;
    run_op(2'd0, 10'h05A, 1'b1, rnd_word(), 1, 1'b0, 0, 0);
    bp_en = 1'b0;

    run_op(2'd3, 10'h222, 1'b0, rnd_word(), 0, 1'b0, 0, 2);
    run_op(2'd2, 10'h333, 1'b0, rnd_word(), 0, 1'b0, 7, 0);

    chk("req_count", 128'(n_req), 128'(exp_req));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
